// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU share arbiter.
package alu_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    OpAnd  = 3'b000,
    OpOr   = 3'b001,
    OpXor  = 3'b010,
    OpAdd  = 3'b011,
    OpSub  = 3'b100,
    OpSlt  = 3'b101,
    OpSlte = 3'b110,
    OpEq   = 3'b111
  } aluop_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr_i, with wrap-around.
module rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]                        req_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
  output logic [N-1:0]                        gnt_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o,
  output logic                                any_o
);

  localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1;

  // Scan N slots starting at the pointer; the first hit wins.
  always_comb begin
    int unsigned k;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr_i) + i) % N;
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IdW'(k);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational 8-bit ALU between NUM_REQ requesters with
// round-robin arbitration and a held response. Optional per-requester
// saturating grant counters are enabled with the ALU_ARB_STATS_EN macro.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*8-1:0]     req_op1,
  input  logic [NUM_REQ*8-1:0]     req_op2,
  input  logic [NUM_REQ*3-1:0]     req_aluop,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [7:0]               rsp_result,
  output logic                     rsp_equal,
  output logic                     rsp_less,
  output logic [7:0]               alu_op1,
  output logic [7:0]               alu_op2,
  output logic [2:0]               alu_aluop,
  input  logic [7:0]               alu_result,
  input  logic                     alu_equal,
  input  logic                     alu_less
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] stat_grants
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || CNT_W < 1) begin : g_bad_param
    $error("alu_share_arbiter: NUM_REQ must be 2..8 and CNT_W >= 1");
  end

  arb_state_t          state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  aluop_t              aluop_q, aluop_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_equal_q, rsp_equal_d;
  logic                rsp_less_q, rsp_less_d;

  logic [NUM_REQ-1:0]  win_gnt;
  logic [IDW-1:0]      win_idx;
  logic                win_any;
  logic                accept;
  int unsigned         sel;

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign accept = (state_q == StIdle) && win_any;
  assign sel    = 32'(win_idx);

  // Next-state, operand latch, response capture and ALU/handshake outputs.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    aluop_d      = aluop_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_equal_d  = rsp_equal_q;
    rsp_less_d   = rsp_less_q;
    req_ready    = '0;
    rsp_valid    = 1'b0;
    alu_op1      = '0;
    alu_op2      = '0;
    alu_aluop    = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = win_gnt;
        if (win_any) begin
          op1_d    = req_op1[sel*DATA_W +: DATA_W];
          op2_d    = req_op2[sel*DATA_W +: DATA_W];
          aluop_d  = aluop_t'(req_aluop[sel*3 +: 3]);
          id_d     = win_idx;
          rr_ptr_d = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
          state_d  = StExec;
        end
      end
      StExec: begin
        alu_op1      = op1_q;
        alu_op2      = op2_q;
        alu_aluop    = aluop_q;
        rsp_id_d     = id_q;
        rsp_result_d = alu_result;
        rsp_equal_d  = alu_equal;
        rsp_less_d   = alu_less;
        state_d      = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pointer, operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      aluop_q      <= OpAnd;
      id_q         <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_equal_q  <= 1'b0;
      rsp_less_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      aluop_q      <= aluop_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_equal_q  <= rsp_equal_d;
      rsp_less_q   <= rsp_less_d;
    end
  end

  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_equal  = rsp_equal_q;
  assign rsp_less   = rsp_less_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic [CNT_W-1:0] cnt_d [NUM_REQ];

  // Saturating per-requester grant counters, bumped on each accept.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept && win_gnt[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Pack counters onto the flat stats port.
  always_comb begin
    stat_grants = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      stat_grants[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
